// File: rtl/reg_file_pkg.sv
// Shared sizing, word type and FSM state encoding for the register file write side.
package reg_file_pkg;

  localparam int WIDTH  = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } rf_state_t;

endpackage

// File: rtl/decoder_3_8.sv
// Address-plus-enable to one-hot select; addresses at or above DEPTH select nothing.
module decoder_3_8 #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [DEPTH-1:0]  o_onehot
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
    assign o_onehot[gi] = i_en && (i_addr == ADDR_W'(gi));
  end

endmodule

// File: rtl/reg_file_write.sv
// Eight-entry register file write side: single-cycle writes gated by wr_ready,
// plus a one-register-per-cycle clear sweep that blocks writes while it runs.
module reg_file_write #(
  parameter int WIDTH  = reg_file_pkg::WIDTH,
  parameter int DEPTH  = reg_file_pkg::DEPTH,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wa,
  input  logic [WIDTH-1:0]             wd,
  output logic                         wr_ready,
  input  logic                         clr_req,
  output logic                         busy,
  output logic [DEPTH-1:0][WIDTH-1:0]  q
);

  import reg_file_pkg::*;

  rf_state_t           r_state;
  rf_state_t           w_state_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_next;
  logic [DEPTH-1:0]    w_write_onehot;
  logic [DEPTH-1:0]    w_clear_onehot;
  logic [WIDTH-1:0]    r_q [DEPTH];
  logic                w_ptr_last;

  assign wr_ready   = (r_state == IDLE);
  assign busy       = (r_state == CLEAR);
  assign w_ptr_last = (r_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // clr_req is only looked at in IDLE, so repeats during a sweep cannot extend it
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_next = CLEAR;
          w_ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (w_ptr_last) begin
          w_state_next = IDLE;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  decoder_3_8 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_write_dec (
    .i_addr   (wa),
    .i_en     (we && wr_ready),
    .o_onehot (w_write_onehot)
  );

  decoder_3_8 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_dec (
    .i_addr   (r_ptr),
    .i_en     (busy),
    .o_onehot (w_clear_onehot)
  );

  // The two selects are never both active (write needs IDLE, clear needs CLEAR);
  // clear is still checked first so a sweep always wins.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_q[gi] <= '0;
      end else if (w_clear_onehot[gi]) begin
        r_q[gi] <= '0;
      end else if (w_write_onehot[gi]) begin
        r_q[gi] <= wd;
      end
    end
    assign q[gi] = r_q[gi];
  end

endmodule

// File: tb/tb_reg_file_write.sv
// Scoreboard bench: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against q/wr_ready/busy.
module tb_reg_file_write;

  import reg_file_pkg::*;

  logic                    clk;
  logic                    reset;
  logic                    we;
  logic [2:0]              wa;
  logic [3:0]              wd;
  logic                    wr_ready;
  logic                    clr_req;
  logic                    busy;
  logic [7:0][3:0]         q;

  typedef struct {
    int    cyc;
    int    idx;
    word_t val;
    logic  rdy;
    logic  bsy;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  reg_file_write dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .busy     (busy),
    .q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every expectation tagged with the current cycle is checked here.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || q[e.idx] !== e.val || wr_ready !== e.rdy || busy !== e.bsy) begin
        errors++;
        $display("FAIL cyc%0d q[%0d]: got q=%h rdy=%b busy=%b, want q=%h rdy=%b busy=%b (tag cyc%0d)",
                 cyc, e.idx, q[e.idx], wr_ready, busy, e.val, e.rdy, e.bsy, e.cyc);
      end else begin
        $display("ok   cyc%0d q[%0d]=%h rdy=%b busy=%b", cyc, e.idx, q[e.idx], wr_ready, busy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int idx, input word_t val, input logic rdy, input logic bsy);
    exp_t e;
    e.cyc = cyc;
    e.idx = idx;
    e.val = val;
    e.rdy = rdy;
    e.bsy = bsy;
    sb.push_back(e);
  endtask

  task automatic write_one(input int a, input word_t d);
    we = 1'b1;
    wa = 3'(a);
    wd = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    clr_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    expect_now(0, 4'h0, 1'b1, 1'b0);
    expect_now(7, 4'h0, 1'b1, 1'b0);

    // Reset between edges clears a freshly written register immediately.
    step();
    write_one(3, 4'hA);
    expect_now(3, 4'hA, 1'b1, 1'b0);
    step();
    #1 reset = 1'b1;
    expect_now(3, 4'h0, 1'b1, 1'b0);
    step();
    reset = 1'b0;

    // Write k+5 to register k, one per cycle.
    for (int k = 0; k < 8; k++) begin
      write_one(k, 4'(k + 5));
      expect_now(k, 4'(k + 5), 1'b1, 1'b0);
    end
    step();
    for (int k = 0; k < 8; k++) expect_now(k, 4'(k + 5), 1'b1, 1'b0);

    // Clear sweep over all-F contents.
    for (int k = 0; k < 8; k++) write_one(k, 4'hF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    expect_now(0, 4'hF, 1'b0, 1'b1);
    for (int j = 1; j <= 7; j++) begin
      step();
      expect_now(j - 1, 4'h0, 1'b0, 1'b1);
      expect_now(j, 4'hF, 1'b0, 1'b1);
    end
    step();
    expect_now(7, 4'h0, 1'b1, 1'b0);

    // Write held during a sweep lands only after IDLE returns.
    write_one(2, 4'h3);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    expect_now(2, 4'h3, 1'b0, 1'b1);
    step();
    expect_now(2, 4'h3, 1'b0, 1'b1);
    step();
    we = 1'b1;
    wa = 3'd2;
    wd = 4'h7;
    expect_now(2, 4'h3, 1'b0, 1'b1);
    for (int j = 3; j <= 8; j++) begin
      step();
      expect_now(2, 4'h0, (j == 8), (j != 8));
    end
    step();
    expect_now(2, 4'h7, 1'b1, 1'b0);
    we = 1'b0;

    // Write and clear on the same edge; a mid-sweep clr_req does not extend busy.
    we      = 1'b1;
    wa      = 3'd6;
    wd      = 4'h9;
    clr_req = 1'b1;
    step();
    we      = 1'b0;
    clr_req = 1'b0;
    expect_now(6, 4'h9, 1'b0, 1'b1);
    for (int j = 1; j <= 9; j++) begin
      step();
      clr_req = (j == 2);
      if (j <= 6)      expect_now(6, 4'h9, 1'b0, 1'b1);
      else if (j == 7) expect_now(6, 4'h0, 1'b0, 1'b1);
      else             expect_now(6, 4'h0, 1'b1, 1'b0);
    end
    clr_req = 1'b0;

    // Reset mid-sweep, then a fresh sweep must start from register 0.
    write_one(5, 4'h5);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    step();
    #1 reset = 1'b1;
    expect_now(5, 4'h0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    write_one(0, 4'h4);
    write_one(7, 4'h4);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    expect_now(0, 4'h4, 1'b0, 1'b1);
    step();
    expect_now(0, 4'h0, 1'b0, 1'b1);
    expect_now(7, 4'h4, 1'b0, 1'b1);
    for (int j = 2; j <= 7; j++) begin
      step();
      expect_now(7, 4'h4, 1'b0, 1'b1);
    end
    step();
    expect_now(7, 4'h0, 1'b1, 1'b0);

    step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
